// File: rtl/muladd_load_sched_if.sv
// Bus between the load sequencer, its operand SRAM and the MulAdd_top load port.
//
// Handshake semantics: start_i is a request taken only when the sequencer is
// idle (abort_i in the same cycle drops it); there is no ready back-pressure
// anywhere. mem_rd_en_o is a read strobe whose data returns on mem_rd_data_i
// one cycle later, and load_en_o is a qualifier: load_payload_o is meaningful
// exactly in the cycles where load_en_o is 1 and is forced to 0 otherwise.
interface muladd_load_sched_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
);
    logic              start_i;
    logic              abort_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rd_data_i;
    logic              load_en_o;
    logic [DATA_W-1:0] load_payload_o;
    logic [2:0]        layer_o;
    logic              busy_o;
    logic              done_o;

    // Sequencer side
    modport slave (
        input  start_i, abort_i, base_addr_i, mem_rd_data_i,
        output mem_rd_en_o, mem_addr_o, load_en_o, load_payload_o,
        output layer_o, busy_o, done_o
    );

    // Host / SRAM side
    modport master (
        output start_i, abort_i, base_addr_i, mem_rd_data_i,
        input  mem_rd_en_o, mem_addr_o, load_en_o, load_payload_o,
        input  layer_o, busy_o, done_o
    );
endinterface

// File: rtl/muladd_load_sched.sv
// Load sequencer: replays a pre-ordered operand image from SRAM as the fixed
// layer burst schedule (one long layer 0, shorter weight layers, idle gaps
// between layers) onto the MulAdd_top load port, two cycles behind the reads.
module muladd_load_sched #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 11,
    parameter int L0_BEATS   = 256,
    parameter int LN_BEATS   = 128,
    parameter int NUM_LAYERS = 8,
    parameter int GAP_CYCLES = 24
) (
    input  logic                clk_data,
    input  logic                rst,
    muladd_load_sched_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam int BEAT_W = $clog2(L0_BEATS > LN_BEATS ? L0_BEATS : LN_BEATS);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] L0_LAST    = BEAT_W'(L0_BEATS - 1);
    localparam logic [BEAT_W-1:0] LN_LAST    = BEAT_W'(LN_BEATS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]        LAST_LAYER = 3'(NUM_LAYERS - 1);

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              drain_q, drain_d;
    logic [2:0]        layer_q, layer_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic              en_d1_q;
    logic              load_en_q;
    logic [DATA_W-1:0] payload_q;
    logic              flush;
    logic [BEAT_W-1:0] layer_last;

    // An abort only matters while a run is in progress; it also empties the load pipeline.
    assign flush      = bus.abort_i && (state_q != S_IDLE);
    assign layer_last = (layer_q == 3'd0) ? L0_LAST : LN_LAST;

    // Schedule walker: the registered read strobe/address for the next cycle
    // are decided together with the state, so the outputs need no decode.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        drain_d = drain_q;
        layer_d = layer_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    state_d = S_STREAM;
                    rd_en_d = 1'b1;
                    addr_d  = bus.base_addr_i;
                    beat_d  = '0;
                    layer_d = 3'd0;
                end
            end
            S_STREAM: begin
                // The address always moves past the beat just read, so after a
                // gap the next layer continues at the following SRAM word.
                addr_d = addr_q + 1'b1;
                if (beat_q == layer_last) begin
                    if (layer_q == LAST_LAYER) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                        layer_d = layer_q + 3'd1;
                    end
                end else begin
                    rd_en_d = 1'b1;
                    beat_d  = beat_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_STREAM;
                    rd_en_d = 1'b1;
                    beat_d  = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                // Two drain cycles let the last read leave the load pipeline.
                if (drain_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
            rd_en_d = 1'b0;
            layer_d = 3'd0;
            done_d  = 1'b0;
        end
    end

    // State, counters and all registered outputs, including the 2-stage load pipeline.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            gap_q     <= '0;
            drain_q   <= 1'b0;
            layer_q   <= 3'd0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            en_d1_q   <= 1'b0;
            load_en_q <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            drain_q   <= drain_d;
            layer_q   <= layer_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            busy_q    <= (state_d != S_IDLE);
            en_d1_q   <= rd_en_q && !flush;
            load_en_q <= en_d1_q && !flush;
            payload_q <= (en_d1_q && !flush) ? bus.mem_rd_data_i : '0;
        end
    end

    assign bus.mem_rd_en_o    = rd_en_q;
    assign bus.mem_addr_o     = addr_q;
    assign bus.load_en_o      = load_en_q;
    assign bus.load_payload_o = payload_q;
    assign bus.layer_o        = layer_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign dbg_state_o        = state_q;
endmodule
